// File: rtl/ucie_ctl_rx_credit_ctrl.sv
// RX buffer credit/occupancy controller for the UCIe controller RX path.
// Define UCIE_CTL_RX_CREDIT_TIMEOUT_EN to force out stale pending credits after TIMEOUT_CYC cycles.
module ucie_ctl_rx_credit_ctrl #(
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 5,
  parameter int RET_THRESH  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_state_request,
  input  logic             i_buffer_enable,
  input  logic             i_flit_valid,
  input  logic             i_flit_consumed,
  output logic             o_credit_return_valid,
  output logic [CNT_W-1:0] o_credit_return_count,
  output logic             o_overflow_detected,
  output logic [CNT_W-1:0] o_occupancy,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_error
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] RET_C   = CNT_W'(RET_THRESH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ACTIVE,
    S_DRAIN,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] occ_nx, occ_drain, pend_nx;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic             ret_valid_q, ret_valid_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             full_q, empty_q;
  logic             wr, rd, ret_fire;

`ifdef UCIE_CTL_RX_CREDIT_TIMEOUT_EN
  localparam int               TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tmo_hit;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  assign wr = i_flit_valid & i_buffer_enable & (state_q == S_ACTIVE);
  assign rd = i_flit_consumed & (occ_q != '0);

  // Simultaneous write and read cancel out; a read at empty is already masked in rd.
  always_comb begin
    occ_nx = occ_q;
    if (wr && !rd) occ_nx = occ_q + CNT_W'(1);
    else if (!wr && rd) occ_nx = occ_q - CNT_W'(1);
  end

  assign occ_drain = rd ? (occ_q - CNT_W'(1)) : occ_q;
  assign pend_nx   = pend_q + CNT_W'(rd);

  always_comb begin
    state_d     = state_q;
    occ_d       = occ_q;
    pend_d      = pend_q;
    ret_valid_d = 1'b0;
    ret_cnt_d   = '0;
    ovf_d       = 1'b0;
    err_d       = err_q;
    ret_fire    = 1'b0;
`ifdef UCIE_CTL_RX_CREDIT_TIMEOUT_EN
    tmr_d   = '0;
    tmo_hit = (pend_q != '0) && (tmr_q == TMR_LAST);
`endif
    case (state_q)
      S_IDLE: begin
        occ_d  = '0;
        pend_d = '0;
        if (i_state_request) state_d = S_INIT;
      end
      S_INIT: begin
        if (i_state_request) begin
          state_d     = S_ACTIVE;
          ret_valid_d = 1'b1;
          ret_cnt_d   = DEPTH_C;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        // Request drop wins over overflow: the cycle is treated as the first drain cycle.
        if (!i_state_request) begin
          state_d = S_DRAIN;
          occ_d   = occ_drain;
          pend_d  = '0;
        end else if (wr && !rd && (occ_q == DEPTH_C)) begin
          state_d = S_ERROR;
          ovf_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          occ_d    = occ_nx;
          ret_fire = (pend_nx >= RET_C) || ((pend_nx != '0) && (occ_nx == '0));
`ifdef UCIE_CTL_RX_CREDIT_TIMEOUT_EN
          ret_fire = ret_fire || tmo_hit;
`endif
          if (ret_fire) begin
            ret_valid_d = 1'b1;
            ret_cnt_d   = pend_nx;
            pend_d      = '0;
          end else begin
            pend_d = pend_nx;
`ifdef UCIE_CTL_RX_CREDIT_TIMEOUT_EN
            if (pend_q != '0) tmr_d = tmr_q + TMR_W'(1);
`endif
          end
        end
      end
      S_DRAIN: begin
        occ_d  = occ_drain;
        pend_d = '0;
        if (occ_drain == '0) state_d = S_IDLE;
      end
      S_ERROR: begin
        if (!i_state_request) begin
          state_d = S_IDLE;
          occ_d   = '0;
          pend_d  = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      occ_q       <= '0;
      pend_q      <= '0;
      ret_valid_q <= 1'b0;
      ret_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      pend_q      <= pend_d;
      ret_valid_q <= ret_valid_d;
      ret_cnt_q   <= ret_cnt_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      full_q      <= (occ_d == DEPTH_C);
      empty_q     <= (occ_d == '0);
    end
  end

`ifdef UCIE_CTL_RX_CREDIT_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) tmr_q <= '0;
    else       tmr_q <= tmr_d;
  end
`endif

  assign o_credit_return_valid = ret_valid_q;
  assign o_credit_return_count = ret_cnt_q;
  assign o_overflow_detected   = ovf_q;
  assign o_occupancy           = occ_q;
  assign o_full                = full_q;
  assign o_empty               = empty_q;
  assign o_error               = err_q;

endmodule

// File: tb/tb_ucie_ctl_rx_credit_ctrl.sv
// Self-checking bench for ucie_ctl_rx_credit_ctrl; credit strobes are scored against a queue of expected counts.
module tb_ucie_ctl_rx_credit_ctrl;
  localparam int DEPTH       = 16;
  localparam int CNT_W       = 5;
  localparam int RET_THRESH  = 4;
  localparam int TIMEOUT_CYC = 64;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_state_request;
  logic             i_buffer_enable;
  logic             i_flit_valid;
  logic             i_flit_consumed;
  logic             o_credit_return_valid;
  logic [CNT_W-1:0] o_credit_return_count;
  logic             o_overflow_detected;
  logic [CNT_W-1:0] o_occupancy;
  logic             o_full;
  logic             o_empty;
  logic             o_error;

  int checks = 0;
  int errors = 0;
  int overflowPulses = 0;
  int expCredits[$];

  ucie_ctl_rx_credit_ctrl #(
    .DEPTH(DEPTH), .CNT_W(CNT_W), .RET_THRESH(RET_THRESH), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_state_request(i_state_request),
    .i_buffer_enable(i_buffer_enable),
    .i_flit_valid(i_flit_valid),
    .i_flit_consumed(i_flit_consumed),
    .o_credit_return_valid(o_credit_return_valid),
    .o_credit_return_count(o_credit_return_count),
    .o_overflow_detected(o_overflow_detected),
    .o_occupancy(o_occupancy),
    .o_full(o_full),
    .o_empty(o_empty),
    .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic en, input logic valid, input logic consumed);
    i_state_request = req;
    i_buffer_enable = en;
    i_flit_valid    = valid;
    i_flit_consumed = consumed;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idleCycles(input int n, input logic req);
    for (int i = 0; i < n; i++) applyStimulus(req, req, 1'b0, 1'b0);
  endtask

  // Every strobe must match the oldest expected credit count; a strobe with nothing queued is an error.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_credit_return_valid) begin
        if (expCredits.size() == 0)
          checkOutput("unexpected_credit_strobe", int'(o_credit_return_valid), 0);
        else
          checkOutput("credit_count", int'(o_credit_return_count), expCredits.pop_front());
      end
      if (o_overflow_detected) overflowPulses++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_rst = 1'b1;
    i_state_request = 1'b0;
    i_buffer_enable = 1'b0;
    i_flit_valid    = 1'b0;
    i_flit_consumed = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset_occupancy", int'(o_occupancy), 0);
    checkOutput("reset_empty", int'(o_empty), 1);
    checkOutput("reset_full", int'(o_full), 0);
    checkOutput("reset_strobe", int'(o_credit_return_valid), 0);
    checkOutput("reset_overflow", int'(o_overflow_detected), 0);
    checkOutput("reset_error", int'(o_error), 0);
    i_rst = 1'b0;

    $display("[TB] link up: initial credit advertisement");
    expCredits.push_back(DEPTH);
    applyStimulus(1, 0, 0, 0);
    checkOutput("init_strobe_early", int'(o_credit_return_valid), 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("init_strobe", int'(o_credit_return_valid), 1);
    checkOutput("init_count", int'(o_credit_return_count), DEPTH);
    checkOutput("init_empty", int'(o_empty), 1);
    applyStimulus(1, 1, 0, 0);
    checkOutput("init_strobe_single", int'(o_credit_return_valid), 0);

    $display("[TB] write 10, read 4");
    repeat (10) applyStimulus(1, 1, 1, 0);
    checkOutput("fill10_occ", int'(o_occupancy), 10);
    expCredits.push_back(4);
    repeat (4) applyStimulus(1, 1, 0, 1);
    checkOutput("read4_strobe", int'(o_credit_return_valid), 1);
    checkOutput("read4_occ", int'(o_occupancy), 6);
    idleCycles(3, 1);
    checkOutput("read4_queue", expCredits.size(), 0);

    $display("[TB] read remaining 6");
    expCredits.push_back(4);
    expCredits.push_back(2);
    repeat (6) applyStimulus(1, 1, 0, 1);
    checkOutput("drain6_occ", int'(o_occupancy), 0);
    checkOutput("drain6_empty", int'(o_empty), 1);
    idleCycles(2, 1);
    checkOutput("drain6_queue", expCredits.size(), 0);

    $display("[TB] read at empty is ignored");
    applyStimulus(1, 1, 0, 1);
    checkOutput("empty_read_occ", int'(o_occupancy), 0);
    idleCycles(3, 1);

    $display("[TB] fill to full, simultaneous write+read, then overflow");
    repeat (16) applyStimulus(1, 1, 1, 0);
    checkOutput("full_occ", int'(o_occupancy), DEPTH);
    checkOutput("full_flag", int'(o_full), 1);
    checkOutput("full_not_empty", int'(o_empty), 0);
    applyStimulus(1, 1, 1, 1);
    checkOutput("wr_rd_full_occ", int'(o_occupancy), DEPTH);
    checkOutput("wr_rd_full_no_ovf", int'(o_overflow_detected), 0);
    expCredits.push_back(4);
    repeat (3) applyStimulus(1, 1, 0, 1);
    checkOutput("wr_rd_pending_occ", int'(o_occupancy), 13);
    idleCycles(2, 1);
    checkOutput("wr_rd_pending_queue", expCredits.size(), 0);
    repeat (3) applyStimulus(1, 1, 1, 0);
    applyStimulus(1, 1, 1, 0);
    checkOutput("ovf_pulse", int'(o_overflow_detected), 1);
    checkOutput("ovf_error", int'(o_error), 1);
    checkOutput("ovf_occ", int'(o_occupancy), DEPTH);
    applyStimulus(1, 1, 0, 1);
    checkOutput("ovf_pulse_end", int'(o_overflow_detected), 0);
    checkOutput("err_sticky", int'(o_error), 1);
    checkOutput("err_frozen_occ", int'(o_occupancy), DEPTH);
    applyStimulus(1, 1, 1, 0);
    checkOutput("err_no_new_pulse", int'(o_overflow_detected), 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("err_clear", int'(o_error), 0);
    checkOutput("err_clear_occ", int'(o_occupancy), 0);
    checkOutput("err_clear_empty", int'(o_empty), 1);

    $display("[TB] relink, drain at occupancy 3");
    expCredits.push_back(DEPTH);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("relink_strobe", int'(o_credit_return_valid), 1);
    repeat (3) applyStimulus(1, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("drain_entry_occ", int'(o_occupancy), 3);
    applyStimulus(0, 1, 1, 0);
    checkOutput("drain_write_ignored", int'(o_occupancy), 3);
    repeat (3) applyStimulus(0, 0, 0, 1);
    checkOutput("drain_done_occ", int'(o_occupancy), 0);
    checkOutput("drain_done_empty", int'(o_empty), 1);
    idleCycles(2, 0);
    checkOutput("drain_no_strobe_queue", expCredits.size(), 0);
    expCredits.push_back(DEPTH);
    applyStimulus(1, 0, 0, 0);
    checkOutput("post_drain_init_gap", int'(o_credit_return_valid), 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("post_drain_strobe", int'(o_credit_return_valid), 1);

    $display("[TB] request reasserts during drain");
    repeat (2) applyStimulus(1, 1, 1, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0);
    checkOutput("reassert_write_ignored", int'(o_occupancy), 2);
    applyStimulus(1, 1, 0, 1);
    checkOutput("reassert_read_occ", int'(o_occupancy), 1);
    expCredits.push_back(DEPTH);
    applyStimulus(1, 1, 0, 1);
    checkOutput("reassert_idle_gap", int'(o_credit_return_valid), 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("reassert_init_gap", int'(o_credit_return_valid), 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("reassert_strobe", int'(o_credit_return_valid), 1);
    checkOutput("reassert_count", int'(o_credit_return_count), DEPTH);

    $display("[TB] single pending credit left idle");
    repeat (5) applyStimulus(1, 1, 1, 0);
    applyStimulus(1, 1, 0, 1);
    checkOutput("stale_occ", int'(o_occupancy), 4);
    idleCycles(TIMEOUT_CYC - 1, 1);
    checkOutput("stale_before_timeout", int'(o_credit_return_valid), 0);
`ifdef UCIE_CTL_RX_CREDIT_TIMEOUT_EN
    expCredits.push_back(1);
    applyStimulus(1, 1, 0, 0);
    checkOutput("timeout_strobe", int'(o_credit_return_valid), 1);
    checkOutput("timeout_count", int'(o_credit_return_count), 1);
    expCredits.push_back(4);
`else
    applyStimulus(1, 1, 0, 0);
    checkOutput("no_timeout_strobe", int'(o_credit_return_valid), 0);
    expCredits.push_back(4);
    expCredits.push_back(1);
`endif
    idleCycles(5, 1);
    repeat (4) applyStimulus(1, 1, 0, 1);
    idleCycles(2, 1);
    checkOutput("final_occ", int'(o_occupancy), 0);
    checkOutput("final_queue", expCredits.size(), 0);
    checkOutput("overflow_pulse_total", overflowPulses, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucie_ctl_rx_credit_ctrl.md
Name: ucie_ctl_rx_credit_ctrl

Overview:
Credit and occupancy controller for the UCIe controller RX buffer. It sits between the link-side RX path and the RX FSM.
- Tracks buffer fill level and advertises initial credits on link activation.
- Batches credit returns to the remote TX as the consumer drains flits.
- Raises a one-cycle overflow pulse, which the RX FSM consumes as its overflow_detected input.
- Sequences a clean drain when the link request drops.

Parameters:
DEPTH, 16, RX buffer depth in flits (credit pool size); must be ≥2.
CNT_W, 5, counter width; must equal clog2(DEPTH+1).
RET_THRESH, 4, pending-credit count that triggers a return; 1 ≤ RET_THRESH ≤ DEPTH.
TIMEOUT_CYC, 64, forced-return timeout in cycles; used only with the optional feature.

Ports:
i_clk  input  1  clock
i_rst  input  1  asynchronous reset, active-high
i_state_request  input  1  link active request, same signal that drives the RX FSM
i_buffer_enable  input  1  buffer write enable from the RX FSM
i_flit_valid  input  1  flit written into RX buffer this cycle
i_flit_consumed  input  1  flit read out of RX buffer this cycle
o_credit_return_valid  output  1  credit return strobe to remote TX
o_credit_return_count  output  CNT_W  number of credits returned; valid only with the strobe
o_overflow_detected  output  1  one-cycle pulse to the RX FSM
o_occupancy  output  CNT_W  current flits held
o_full  output  1  occupancy == DEPTH
o_empty  output  1  occupancy == 0
o_error  output  1  sticky overflow error flag

Behaviour:
- Reset (async, i_rst=1):
  - state = IDLE; occupancy = 0; pending = 0.
  - All outputs 0, except o_empty = 1.
- All outputs are registered. Strobes appear the cycle after the qualifying condition.
- Write: wr = i_flit_valid & i_buffer_enable, in ACTIVE only.
- Read: rd = i_flit_consumed & (occupancy > 0). A read at empty is ignored, with no occupancy or credit change.
- Occupancy: +1 on wr only, -1 on rd only, unchanged when both occur.
- IDLE:
  - Counters held at 0.
  - i_state_request=1 -> INIT.
- INIT (exactly 1 cycle):
  - Next cycle: o_credit_return_valid=1, count=DEPTH.
  - -> ACTIVE. If i_state_request has dropped, -> IDLE with no credit strobe.
- ACTIVE:
  - Each rd adds 1 to pending.
  - Return fires when pending_next ≥ RET_THRESH, or pending_next > 0 and occupancy_next == 0.
  - On return: strobe with count = pending_next; pending cleared to 0.
  - Overflow = wr & !rd & occupancy == DEPTH. Next cycle: o_overflow_detected=1 (1 cycle), o_error=1; -> ERROR. Occupancy is not incremented.
  - Simultaneous wr+rd at full is legal: no overflow.
  - i_state_request=0 (highest priority over overflow) -> DRAIN.
- DRAIN:
  - Writes ignored; reads continue.
  - No credit returns; pending discarded.
  - When occupancy reaches 0 -> IDLE.
  - If i_state_request reasserts, stay in DRAIN until empty, then -> IDLE, then -> INIT on the next cycle.
- ERROR:
  - Counters frozen; no strobes; o_error held.
  - i_state_request=0 -> IDLE. On that transition occupancy, pending and o_error clear.
- Invariant: credits outstanding at the remote TX + occupancy + pending == DEPTH while in ACTIVE.
- o_credit_return_count never exceeds DEPTH.
- o_full and o_empty are derived from the registered occupancy.

Optional Feature:
UCIE_CTL_RX_CREDIT_TIMEOUT_EN
- Defined:
  - A timeout counter runs while in ACTIVE with pending > 0 and no return issued.
  - After TIMEOUT_CYC consecutive cycles, all pending credits are forced out (strobe, count = pending) and the counter clears.
  - The counter also clears on any return, and on leaving ACTIVE.
- Undefined: no timeout counter is built, and TIMEOUT_CYC is unused. Returns fire only on the threshold or empty condition.

Test Plan:
- Reset then i_state_request=1 -> one strobe with count=16, two cycles after request; state ACTIVE; o_empty=1.
- Write 10 flits, then read 4 -> one strobe count=4; occupancy=6; no further strobes.
- Read the remaining 6 -> strobe count=4 at the threshold, then strobe count=2 when occupancy reaches 0.
- Fill to 16, then a write with no read -> o_overflow_detected high exactly 1 cycle; o_error=1; occupancy stays 16; drop request -> IDLE, o_error=0.
- At occupancy 16, wr+rd in the same cycle -> no overflow; occupancy stays 16; pending=1.
- Request drop at occupancy 3 -> writes ignored, no strobes; 3 reads -> IDLE. With TIMEOUT_EN and RET_THRESH=4: 1 read at occupancy 5 -> strobe count=1 after 64 idle cycles.
